// File: rtl/dcm_sup_pkg.sv
// Shared definitions for the DCM lock supervisor: state encoding, default
// parameter values and a small helper for sizing the shared cycle counter.
package dcm_sup_pkg;

   typedef enum logic [2:0] {
      ST_ASSERT_RST = 3'd0,
      ST_WAIT_LOCK  = 3'd1,
      ST_SETTLE     = 3'd2,
      ST_RUN        = 3'd3,
      ST_FAIL       = 3'd4
   } state_e;

   localparam int DEF_RST_CYCLES    = 8;
   localparam int DEF_LOCK_TIMEOUT  = 4096;
   localparam int DEF_SETTLE_CYCLES = 16;
   localparam int DEF_MAX_RETRY     = 15;
   localparam int DEF_HB_TIMEOUT    = 256;
   localparam int RETRY_W           = 4;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop synchronizer for a single asynchronous level into the i_clk domain.
module sync_2ff #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbour; blocking here would collapse the chain.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/dcm_lock_supervisor.sv
// Resets the CMS/DDU DCMs, waits for both to lock and settle, retries on loss.
// Optional heartbeat watchdog in RUN is built when DCM_SUP_HB_MON_EN is defined.
module dcm_lock_supervisor
   import dcm_sup_pkg::*;
#(
   parameter int RST_CYCLES    = DEF_RST_CYCLES,
   parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int MAX_RETRY     = DEF_MAX_RETRY,
   parameter int HB_TIMEOUT    = DEF_HB_TIMEOUT
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_cms_locked,
   input  logic               i_ddu_locked,
   input  logic               i_dv128_hb,
   output logic               o_dcm_rst,
   output logic               o_ready,
   output logic               o_fail,
   output logic [RETRY_W-1:0] o_retry_cnt
);

   localparam int CNT_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES)) + 1;
   localparam int SET_W = $clog2(SETTLE_CYCLES) + 1;

   logic w_cms_sync;
   logic w_ddu_sync;
   logic w_locks_ok;
   logic w_hb_expired;

   state_e             r_state;
   state_e             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic               w_cnt_clr;
   logic [SET_W-1:0]   r_settle_cnt;
   logic [RETRY_W-1:0] r_retry;
   logic [RETRY_W-1:0] w_retry_nxt;
   logic               w_fail_evt;

   sync_2ff #(.STAGES(2)) u_cms_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_cms_locked),
      .o_q     (w_cms_sync)
   );

   sync_2ff #(.STAGES(2)) u_ddu_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_ddu_locked),
      .o_q     (w_ddu_sync)
   );

   assign w_locks_ok = w_cms_sync & w_ddu_sync;

`ifdef DCM_SUP_HB_MON_EN
   localparam int HB_W = $clog2(HB_TIMEOUT) + 1;

   logic            w_hb_sync;
   logic            r_hb_d;
   logic            w_hb_edge;
   logic [HB_W-1:0] r_hb_cnt;

   // Two sync stages plus r_hb_d form the 3-flop chain; edge detect on the last two.
   sync_2ff #(.STAGES(2)) u_hb_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_dv128_hb),
      .o_q     (w_hb_sync)
   );

   assign w_hb_edge    = w_hb_sync ^ r_hb_d;
   assign w_hb_expired = (r_state == ST_RUN) && !w_hb_edge &&
                         (r_hb_cnt == HB_W'(HB_TIMEOUT - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hb_d   <= 1'b0;
         r_hb_cnt <= '0;
      end else begin
         r_hb_d <= w_hb_sync;
         if ((r_state != ST_RUN) || w_hb_edge) begin
            r_hb_cnt <= '0;
         end else if (!w_hb_expired) begin
            r_hb_cnt <= r_hb_cnt + 1'b1;
         end
      end
   end
`else
   logic w_unused_hb;

   assign w_unused_hb  = i_dv128_hb;
   assign w_hb_expired = 1'b0;
`endif

   // NOTE: every signal driven here gets a default first so no path leaves it
   // unassigned; a missing default in always_comb infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_retry_nxt = r_retry;
      w_fail_evt  = 1'b0;

      unique case (r_state)
         ST_ASSERT_RST: begin
            if (r_cnt == CNT_W'(RST_CYCLES - 1)) begin
               w_state_nxt = ST_WAIT_LOCK;
            end
         end
         ST_WAIT_LOCK: begin
            if (w_locks_ok) begin
               w_state_nxt = ST_SETTLE;
            end else if (r_cnt >= CNT_W'(LOCK_TIMEOUT - 1)) begin
               w_fail_evt = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (!w_locks_ok) begin
               w_state_nxt = ST_WAIT_LOCK;
            end else if (r_settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            // Lock loss and heartbeat timeout together are still one event.
            if (!w_locks_ok || w_hb_expired) begin
               w_fail_evt = 1'b1;
            end
         end
         ST_FAIL: begin
            w_state_nxt = ST_FAIL;
         end
         default: begin
            w_state_nxt = ST_ASSERT_RST;
         end
      endcase

      if (w_fail_evt) begin
         if (r_retry < RETRY_W'(MAX_RETRY)) begin
            w_retry_nxt = r_retry + 1'b1;
            w_state_nxt = ST_ASSERT_RST;
         end else begin
            w_state_nxt = ST_FAIL;
         end
      end
   end

   // The lock timeout spans WAIT_LOCK and SETTLE together, so bouncing between
   // them keeps counting instead of restarting the window.
   assign w_cnt_clr = (w_state_nxt != r_state) &&
                      !((r_state == ST_WAIT_LOCK) && (w_state_nxt == ST_SETTLE)) &&
                      !((r_state == ST_SETTLE) && (w_state_nxt == ST_WAIT_LOCK));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= ST_ASSERT_RST;
         r_cnt        <= '0;
         r_settle_cnt <= '0;
         r_retry      <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_retry <= w_retry_nxt;

         if (w_cnt_clr) begin
            r_cnt <= '0;
         end else if (((r_state == ST_ASSERT_RST) || (r_state == ST_WAIT_LOCK) ||
                       (r_state == ST_SETTLE)) && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
         end

         // The WAIT_LOCK cycle that saw both locks high is the first settle cycle.
         if (r_state == ST_SETTLE) begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
         end else begin
            r_settle_cnt <= SET_W'(1);
         end
      end
   end

   assign o_dcm_rst   = (r_state == ST_ASSERT_RST);
   assign o_ready     = (r_state == ST_RUN);
   assign o_fail      = (r_state == ST_FAIL);
   assign o_retry_cnt = r_retry;

endmodule
